reg_transfer_ctrl: RTL and testbench
====================================

// Module: reg_transfer_ctrl
// PURPOSE
//   Sequencer upstream of the 32-bit bus registers. Accepts one transfer request at a time:
//   - register-to-register move, or
//   - immediate load.
//   Drives per-register tri-state read enables and write enables so that at most one
//   register drives the shared bus, and at most one is written.
//   Samples the shared bus and returns the moved data with a completion pulse.
// PARAMETERS
//   NUM_REGS  8                   number of attached registers (2..32)
//   DATA_W    32                  bus / register data width
//   IDX_W     $clog2(NUM_REGS)    register index width (derived, not overridden)
// PORTS
//   clk          in   1         single clock, rising edge
//   reset        in   1         asynchronous, active-low reset
//   req_valid    in   1         request present
//   req_ready    out  1         controller can accept (high only in IDLE)
//   req_imm_en   in   1         1 = immediate load, 0 = register move
//   req_src      in   IDX_W     source register index (ignored when req_imm_en=1)
//   req_dst      in   IDX_W     destination register index
//   req_imm      in   DATA_W    immediate value
//   rd_en        out  NUM_REGS  per-register read_enable; register drives bus when its bit is 0, Hi-Z when 1
//   wr_en        out  NUM_REGS  per-register write_enable, one-cycle pulse
//   wr_data      out  DATA_W    data presented to all register write_data inputs
//   bus_in       in   DATA_W    shared tri-state bus
//   done         out  1         one-cycle completion pulse
//   done_data    out  DATA_W    value written, valid while done=1
//   err          out  1         one-cycle pulse: out-of-range index, request dropped
// BEHAVIOUR
//   Reset values (asserted anytime, incl. mid-transfer):
//     - rd_en = all 1s, wr_en = 0, wr_data = 0, done = 0, done_data = 0, err = 0
//     - state = IDLE, req_ready = 1
//     - a transfer interrupted by reset is abandoned; no partial write occurs after release.
//   Handshake: request accepted on the cycle req_valid & req_ready.
//     - src/dst/imm/imm_en are captured into internal registers on acceptance.
//     - Inputs are don't-care afterwards.
//   FSM states: IDLE, DRIVE, CAPTURE, WRITE, DONE.
//   IDLE -> DRIVE on accept of a move:
//     - if req_src or req_dst >= NUM_REGS: stay IDLE, pulse err next cycle, no enables toggle.
//   IDLE -> WRITE on accept of an immediate:
//     - wr_data <= req_imm.
//     - dst range check as above.
//   DRIVE (1 cycle): rd_en[src] = 0, all others 1; bus settles.
//   CAPTURE (1 cycle): rd_en[src] still 0; wr_data <= bus_in at end of cycle.
//   WRITE (1 cycle): rd_en = all 1s; wr_en[dst] = 1 (one-hot).
//     - Register latches wr_data on this edge.
//   DONE (1 cycle): done = 1, done_data = wr_data; next state IDLE.
//   Latency, acceptance edge to done high:
//     - move: 4 cycles.
//     - immediate: 2 cycles.
//     - req_ready low from the cycle after acceptance through DONE.
//   Invariants:
//     - rd_en has at most one 0 bit in every cycle.
//     - wr_en has at most one 1 bit.
//     - no cycle has both a read-enable low and a write-enable high.
//   src == dst is legal: register is rewritten with its own value.
//   All outputs are registered; no combinational path from req_* to rd_en/wr_en.
//   NUM_REGS not a power of 2: indices NUM_REGS..2^IDX_W-1 are out of range (err).
// STRUCTURE
//   Package reg_xfer_pkg:
//     - state_t enum {IDLE, DRIVE, CAPTURE, WRITE, DONE}
//     - localparam MOVE_LAT = 4, IMM_LAT = 2
//   Sub-module onehot_decode #(N, W):
//     - index + enable -> N-bit one-hot
//     - used for rd_en (inverted) and wr_en.
//   Everything else (FSM, capture register, range check) stays in this module.
// TESTING
//   - Reset: hold reset=0, bus_in=X
//     -> rd_en = 8'hFF, wr_en = 0, req_ready = 1, done = 0.
//   - Move: src=2, dst=5, bus_in = 32'hDEAD_BEEF while rd_en[2]=0
//     -> rd_en = 8'hFB for 2 cycles; wr_en = 8'h20 for 1 cycle with wr_data = 32'hDEAD_BEEF;
//        done 4 cycles after accept.
//   - Immediate: dst=0, imm = 32'h0000_1234
//     -> wr_en = 8'h01 one cycle after accept; done_data = 32'h1234 two cycles after accept.
//   - Out-of-range: NUM_REGS=6, dst=7
//     -> err pulse, wr_en stays 0, rd_en stays all 1s, req_ready stays 1.
//   - Back-to-back: req_valid held high with 3 queued moves
//     -> each accepted only in IDLE; one-hot rd_en/wr_en invariant asserted every cycle.
//   - Reset during CAPTURE of move src=1, dst=3
//     -> rd_en = all 1s immediately (async); wr_en[3] never pulses; IDLE after release.

Source files
------------

// File: rtl/reg_xfer_pkg.sv
// Shared types and helpers for the register transfer sequencer.
// Holds the FSM state encoding, the nominal request latencies and the index range check.
package reg_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    // Cycles from the acceptance edge to the cycle in which done is high.
    localparam int MOVE_LAT = 4;
    localparam int IMM_LAT  = 2;

    function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Index plus enable to an N-bit one-hot vector.
// Indices at or above N decode to all zeros.
module onehot_decode #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_transfer_ctrl.sv
// Sequencer for moves and immediate loads between registers on a shared tri-state bus.
// Every output is registered, so enables change only on clock edges or on reset.
module reg_transfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter  int NUM_REGS = 8,
    parameter  int DATA_W   = 32,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_imm_en,
    input  logic [IDX_W-1:0]    req_src,
    input  logic [IDX_W-1:0]    req_dst,
    input  logic [DATA_W-1:0]   req_imm,
    output logic [NUM_REGS-1:0] rd_en,
    output logic [NUM_REGS-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W-1:0]   bus_in,
    output logic                done,
    output logic [DATA_W-1:0]   done_data,
    output logic                err
);

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    src_q;
    logic [IDX_W-1:0]    dst_q;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                accept;
    logic                idx_bad;
    logic                start;
    logic                rd_active;
    logic                wr_active;
    logic [NUM_REGS-1:0] rd_sel;
    logic [NUM_REGS-1:0] wr_sel;

    // The source index only matters for moves; an immediate checks just the destination.
    assign accept  = req_valid && req_ready;
    assign idx_bad = !idx_in_range(32'(req_dst), NUM_REGS) ||
                     (!req_imm_en && !idx_in_range(32'(req_src), NUM_REGS));
    assign start   = accept && !idx_bad;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = req_imm_en ? WRITE : DRIVE;
            DRIVE:   state_next = CAPTURE;
            CAPTURE: state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Enables are decoded for the state being entered, then registered alongside it.
    assign rd_idx    = (state == IDLE) ? req_src : src_q;
    assign wr_idx    = (state == IDLE) ? req_dst : dst_q;
    assign rd_active = (state_next == DRIVE) || (state_next == CAPTURE);
    assign wr_active = (state_next == WRITE);

    onehot_decode #(.N(NUM_REGS), .W(IDX_W)) u_rd_decode (
        .idx    (rd_idx),
        .en     (rd_active),
        .onehot (rd_sel)
    );

    onehot_decode #(.N(NUM_REGS), .W(IDX_W)) u_wr_decode (
        .idx    (wr_idx),
        .en     (wr_active),
        .onehot (wr_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rd_en     <= '1;
            wr_en     <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            done_data <= '0;
            err       <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_next;
            rd_en     <= ~rd_sel;
            wr_en     <= wr_sel;
            req_ready <= (state_next == IDLE);
            done      <= (state_next == DONE);
            err       <= accept && idx_bad;
            if (start) begin
                src_q <= req_src;
                dst_q <= req_dst;
            end
            if (start && req_imm_en) begin
                wr_data <= req_imm;
            end else if (state == CAPTURE) begin
                wr_data <= bus_in;
            end
            if (state == WRITE) begin
                done_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Directed bench for reg_transfer_ctrl: an 8-register instance with a bus/register model
// and a 6-register instance for out-of-range indices.
module tb_reg_transfer_ctrl;
    import reg_xfer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    int          errors = 0;
    int          checks = 0;

    logic        req_valid, req_ready, req_imm_en, done, err;
    logic [2:0]  req_src, req_dst;
    logic [31:0] req_imm, wr_data, bus_in, done_data;
    logic [7:0]  rd_en, wr_en;
    logic [31:0] regs [8];

    logic        req_valid6, req_ready6, req_imm_en6, done6, err6;
    logic [2:0]  req_src6, req_dst6;
    logic [31:0] req_imm6, wr_data6, done_data6;
    logic [31:0] bus_in6 = 32'h0;
    logic [5:0]  rd_en6, wr_en6;

    always #5 clk = ~clk;

    reg_transfer_ctrl #(.NUM_REGS(8), .DATA_W(32)) u_dut8 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_imm_en(req_imm_en), .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
        .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data), .bus_in(bus_in),
        .done(done), .done_data(done_data), .err(err)
    );

    reg_transfer_ctrl #(.NUM_REGS(6), .DATA_W(32)) u_dut6 (
        .clk(clk), .reset(reset), .req_valid(req_valid6), .req_ready(req_ready6),
        .req_imm_en(req_imm_en6), .req_src(req_src6), .req_dst(req_dst6), .req_imm(req_imm6),
        .rd_en(rd_en6), .wr_en(wr_en6), .wr_data(wr_data6), .bus_in(bus_in6),
        .done(done6), .done_data(done_data6), .err(err6)
    );

    // Register file model: drives the bus when selected, latches wr_data on its write pulse.
    always_comb begin
        bus_in = 'x;
        for (int i = 0; i < 8; i++) begin
            if (!rd_en[i]) bus_in = regs[i];
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 32'(i) * 32'h1111_1111;
            regs[2] <= 32'hDEAD_BEEF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i]) regs[i] <= wr_data;
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic imm_en, input logic [2:0] src,
                                  input logic [2:0] dst, input logic [31:0] imm);
        req_valid  = v;
        req_imm_en = imm_en;
        req_src    = src;
        req_dst    = dst;
        req_imm    = imm;
    endtask

    // Bus-exclusivity invariants, sampled mid-cycle.
    always @(negedge clk) begin
        check_output("inv_rd_onehot", 64'($onehot0(~rd_en)), 64'd1);
        check_output("inv_wr_onehot", 64'($onehot0(wr_en)), 64'd1);
        check_output("inv_rd_wr_excl", 64'((rd_en != 8'hFF) && (wr_en != 8'h00)), 64'd0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [2:0]  b2b_src [3];
        logic [2:0]  b2b_dst [3];
        logic [31:0] b2b_exp [3];
        int          n;

        b2b_src = '{3'd0, 3'd5, 3'd3};
        b2b_dst = '{3'd1, 3'd6, 3'd3};
        b2b_exp = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h3333_3333};

        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0, 32'h0);
        req_valid6 = 1'b0; req_imm_en6 = 1'b0; req_src6 = 3'd0; req_dst6 = 3'd0; req_imm6 = 32'h0;
        repeat (2) tick();
        check_output("reset_rd_en", 64'(rd_en), 64'hFF);
        check_output("reset_wr_en", 64'(wr_en), 64'h00);
        check_output("reset_req_ready", 64'(req_ready), 64'd1);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_err", 64'(err), 64'd0);
        check_output("reset_wr_data", 64'(wr_data), 64'h0);
        check_output("reset_done_data", 64'(done_data), 64'h0);
        reset = 1'b1;
        tick();

        $display("[TB] move src=2 dst=5");
        apply_stimulus(1'b1, 1'b0, 3'd2, 3'd5, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0, 32'h0);
        check_output("mv_drive_rd_en", 64'(rd_en), 64'hFB);
        check_output("mv_drive_wr_en", 64'(wr_en), 64'h00);
        check_output("mv_drive_ready", 64'(req_ready), 64'd0);
        tick();
        check_output("mv_capture_rd_en", 64'(rd_en), 64'hFB);
        check_output("mv_capture_done", 64'(done), 64'd0);
        tick();
        check_output("mv_write_rd_en", 64'(rd_en), 64'hFF);
        check_output("mv_write_wr_en", 64'(wr_en), 64'h20);
        check_output("mv_write_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
        tick();
        check_output("mv_done", 64'(done), 64'd1);
        check_output("mv_done_data", 64'(done_data), 64'hDEAD_BEEF);
        check_output("mv_done_wr_en", 64'(wr_en), 64'h00);
        check_output("mv_done_ready", 64'(req_ready), 64'd0);
        tick();
        check_output("mv_idle_done", 64'(done), 64'd0);
        check_output("mv_idle_ready", 64'(req_ready), 64'd1);

        $display("[TB] immediate dst=0 imm=0x1234");
        apply_stimulus(1'b1, 1'b1, 3'd0, 3'd0, 32'h0000_1234);
        tick();
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0, 32'h0);
        check_output("imm_write_wr_en", 64'(wr_en), 64'h01);
        check_output("imm_write_rd_en", 64'(rd_en), 64'hFF);
        check_output("imm_write_wr_data", 64'(wr_data), 64'h1234);
        tick();
        check_output("imm_done", 64'(done), 64'd1);
        check_output("imm_done_data", 64'(done_data), 64'h1234);
        check_output("imm_done_wr_en", 64'(wr_en), 64'h00);
        tick();
        check_output("imm_idle_ready", 64'(req_ready), 64'd1);

        $display("[TB] out-of-range on 6-register instance");
        req_valid6 = 1'b1; req_imm_en6 = 1'b1; req_dst6 = 3'd7; req_imm6 = 32'hAAAA_AAAA;
        tick();
        req_valid6 = 1'b0;
        check_output("oor_imm_err", 64'(err6), 64'd1);
        check_output("oor_imm_wr_en", 64'(wr_en6), 64'h00);
        check_output("oor_imm_rd_en", 64'(rd_en6), 64'h3F);
        check_output("oor_imm_ready", 64'(req_ready6), 64'd1);
        tick();
        check_output("oor_imm_err_clear", 64'(err6), 64'd0);
        check_output("oor_imm_wr_en_after", 64'(wr_en6), 64'h00);
        req_valid6 = 1'b1; req_imm_en6 = 1'b0; req_src6 = 3'd6; req_dst6 = 3'd1;
        tick();
        req_valid6 = 1'b0;
        check_output("oor_src_err", 64'(err6), 64'd1);
        check_output("oor_src_rd_en", 64'(rd_en6), 64'h3F);
        check_output("oor_src_ready", 64'(req_ready6), 64'd1);
        tick();
        check_output("oor_src_rd_en_after", 64'(rd_en6), 64'h3F);
        req_valid6 = 1'b1; req_imm_en6 = 1'b1; req_dst6 = 3'd5; req_imm6 = 32'h0000_0055;
        tick();
        req_valid6 = 1'b0;
        check_output("edge_dst5_err", 64'(err6), 64'd0);
        check_output("edge_dst5_wr_en", 64'(wr_en6), 64'h20);
        check_output("edge_dst5_wr_data", 64'(wr_data6), 64'h55);
        tick();
        check_output("edge_dst5_done", 64'(done6), 64'd1);
        check_output("edge_dst5_done_data", 64'(done_data6), 64'h55);
        tick();

        $display("[TB] back-to-back moves with req_valid held");
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b0, b2b_src[k], b2b_dst[k], 32'h0);
            n = 0;
            while (!req_ready && n < 20) begin
                tick();
                n++;
            end
            check_output("b2b_ready_wait", 64'(n < 20), 64'd1);
            tick();
            if (k == 2) apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0, 32'h0);
            check_output("b2b_accept_ready_low", 64'(req_ready), 64'd0);
            n = 1;
            while (!done && n < 20) begin
                tick();
                n++;
                if (!done) check_output("b2b_busy_ready_low", 64'(req_ready), 64'd0);
            end
            check_output("b2b_latency", 64'(n), 64'(MOVE_LAT));
            check_output("b2b_done_data", 64'(done_data), 64'(b2b_exp[k]));
        end
        tick();
        check_output("b2b_final_ready", 64'(req_ready), 64'd1);
        check_output("b2b_reg6_model", 64'(regs[6]), 64'hDEAD_BEEF);

        $display("[TB] reset during capture, move src=1 dst=3");
        apply_stimulus(1'b1, 1'b0, 3'd1, 3'd3, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0, 32'h0);
        tick();
        check_output("rst_capture_rd_en", 64'(rd_en), 64'hFD);
        #1;
        reset = 1'b0;
        #1;
        check_output("rst_async_rd_en", 64'(rd_en), 64'hFF);
        check_output("rst_async_wr_en", 64'(wr_en), 64'h00);
        check_output("rst_async_ready", 64'(req_ready), 64'd1);
        check_output("rst_async_done", 64'(done), 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_output("rst_after_wr_en", 64'(wr_en), 64'h00);
            check_output("rst_after_rd_en", 64'(rd_en), 64'hFF);
            check_output("rst_after_ready", 64'(req_ready), 64'd1);
            check_output("rst_after_done", 64'(done), 64'd0);
        end
        check_output("imm_lat_const", 64'(IMM_LAT), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
